// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. Each operation takes three
// cycles (IDLE -> EXEC -> DONE). The winner's operands are captured when it
// is granted. The result and flags are registered when the operation
// completes.
//
// Arbitration:
//   Macro ALU_ARB_RR_EN defined   : round-robin. On simultaneous requests
//                                   the port that was not granted last wins.
//   Macro ALU_ARB_RR_EN undefined : fixed priority. Port 0 wins.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req0/a0/b0/op0      requester 0 request, operands, op code
//   req1/a1/b1/op1      requester 1 request, operands, op code
//   gnt0/gnt1           high for the EXEC cycle of the granted port
//   done0/done1         high for the DONE cycle of the owning port
//   result              result of the last completed op (DW bits)
//   ALUFlags            {N,Z,C,V} of the last completed op
//   busy                high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [1:0]    op0,
  input  logic          req1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  input  logic [1:0]    op1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] result,
  output logic [3:0]    ALUFlags,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q;
  logic [DW-1:0] a_q, b_q;
  logic [1:0]    op_q;
  logic          load;
  logic          win;

`ifdef ALU_ARB_RR_EN
  logic          last_q;   // 1: port 1 was granted last
`endif

  // ALU datapath on the captured operands
  logic [DW-1:0] b_eff;
  logic          cin;
  logic [DW:0]   sum;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_v;

  always_comb begin
    b_eff   = op_q[0] ? ~b_q : b_q;
    cin     = op_q[0];
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{DW{1'b0}}, cin};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      2'b00, 2'b01: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        // Overflow: both addends have the same sign and the sum's sign differs.
        alu_v   = (a_q[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a_q[DW-1]);
      end
      2'b10:   alu_res = a_q & b_q;
      default: alu_res = a_q | b_q;
    endcase
  end

  // Winner selection, used only when leaving IDLE
  always_comb begin
`ifdef ALU_ARB_RR_EN
    win = (req0 && req1) ? ~last_q : req1;
`else
    win = ~req0;
`endif
  end

  // Next state and decoded outputs
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        gnt0    = ~owner_q;
        gnt1    = owner_q;
        state_d = DONE;
      end
      DONE: begin
        done0   = ~owner_q;
        done1   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result   <= '0;
      ALUFlags <= '0;
`ifdef ALU_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        owner_q <= win;
        a_q     <= win ? a1  : a0;
        b_q     <= win ? b1  : b0;
        op_q    <= win ? op1 : op0;
`ifdef ALU_ARB_RR_EN
        last_q  <= win;
`endif
      end
      if (state_q == EXEC) begin
        result   <= alu_res;
        ALUFlags <= {alu_res[DW-1], (alu_res == '0), alu_c, alu_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int DW = 5;

  logic          clk, reset;
  logic          req0, req1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [1:0]    op0, op1;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [DW-1:0] result;
  logic [3:0]    ALUFlags;

  alu_arbiter #(.DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .ALUFlags(ALUFlags), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU computed from integer arithmetic; returns {N,Z,C,V,result}
  function automatic logic [DW+3:0] alu_ref(input int a, input int b, input int op);
    int full, half, r, sa, sb, sr;
    logic c, v, n, z;
    full = 1 << DW;
    half = 1 << (DW - 1);
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin r = a + b;        c = (r >= full); sr = sa + sb; v = (sr >= half) || (sr < -half); end
      1: begin r = a - b + full; c = (a >= b);    sr = sa - sb; v = (sr >= half) || (sr < -half); end
      2: r = a & b;
      default: r = a | b;
    endcase
    r = r % full;
    n = (r >= half);
    z = (r == 0);
    return {n, z, c, v, r[DW-1:0]};
  endfunction

  // Behavioural model: phase 0 idle, 1 granted, 2 completing
  int            ph = 0;
  logic          m_owner = 1'b0;
  logic          m_last = 1'b1;
  int            ta, tb, top;
  logic [DW-1:0] m_res = '0;
  logic [3:0]    m_flags = '0;
  logic          chk_en = 1'b0;

  always @(posedge clk) begin
    logic [DW+3:0] rf;
    logic          w;
    if (reset) begin
      ph = 0; m_res = '0; m_flags = '0; m_last = 1'b1; m_owner = 1'b0;
    end else begin
      case (ph)
        0: if (req0 || req1) begin
`ifdef ALU_ARB_RR_EN
          if (req0 && req1) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
          else              w = req1;
`else
          w = !req0;
`endif
          m_owner = w;
          m_last  = w;
          ta  = w ? int'(a1)  : int'(a0);
          tb  = w ? int'(b1)  : int'(b0);
          top = w ? int'(op1) : int'(op0);
          ph  = 1;
        end
        1: begin
          rf = alu_ref(ta, tb, top);
          m_res   = rf[DW-1:0];
          m_flags = rf[DW+3:DW];
          ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt0",  32'(gnt0),  32'(ph == 1 && !m_owner));
      check("gnt1",  32'(gnt1),  32'(ph == 1 &&  m_owner));
      check("done0", 32'(done0), 32'(ph == 2 && !m_owner));
      check("done1", 32'(done1), 32'(ph == 2 &&  m_owner));
      check("busy",  32'(busy),  32'(ph != 0));
      check("result", 32'(result), 32'(m_res));
      check("flags", 32'(ALUFlags), 32'(m_flags));
    end
  end

  // Called at posedge+2 in IDLE; drives one request and checks the literals
  task automatic op_run(input logic port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] op, input logic [DW-1:0] exp_r,
                        input logic [3:0] exp_f, input logic mutate);
    if (port) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    @(posedge clk); #2;
    check("dir_gnt", 32'(port ? gnt1 : gnt0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    if (mutate) begin a0 = ~a; a1 = ~a; b0 = ~b; b1 = ~b; end
    @(posedge clk); #2;
    check("dir_done",   32'(port ? done1 : done0), 32'd1);
    check("dir_result", 32'(result),   32'(exp_r));
    check("dir_flags",  32'(ALUFlags), 32'(exp_f));
    @(posedge clk); #2;
    check("dir_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;

    // Pin the reference ALU with hand-computed values
    check("ref_add", 32'(alu_ref(5, 3, 0)),   32'({4'b0000, 5'b01000}));
    check("ref_ovf", 32'(alu_ref(15, 1, 0)),  32'({4'b1001, 5'b10000}));
    check("ref_sub", 32'(alu_ref(3, 3, 1)),   32'({4'b0110, 5'b00000}));
    check("ref_and", 32'(alu_ref(6, 12, 2)),  32'({4'b0000, 5'b00100}));

    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_result", 32'(result),   32'd0);
    check("rst_flags",  32'(ALUFlags), 32'd0);
    check("rst_gnt",    32'({gnt0, gnt1, done0, done1}), 32'd0);
    reset = 1'b0;

    op_run(1'b0, 5'd5,  5'd3,  2'b00, 5'b01000, 4'b0000, 1'b0);
    op_run(1'b1, 5'd15, 5'd1,  2'b00, 5'b10000, 4'b1001, 1'b0);
    op_run(1'b0, 5'd3,  5'd3,  2'b01, 5'b00000, 4'b0110, 1'b0);
    op_run(1'b0, 5'd6,  5'd12, 2'b10, 5'b00100, 4'b0000, 1'b0);
    op_run(1'b0, 5'd5,  5'd3,  2'b00, 5'b01000, 4'b0000, 1'b1);

    // Reset during EXEC aborts the operation
    req0 = 1'b1; a0 = 5'd15; b0 = 5'd1; op0 = 2'b00;
    @(posedge clk); #2;
    check("abort_gnt", 32'(gnt0), 32'd1);
    reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #2;
    check("abort_done",   32'(done0),    32'd0);
    check("abort_busy",   32'(busy),     32'd0);
    check("abort_result", 32'(result),   32'd0);
    check("abort_flags",  32'(ALUFlags), 32'd0);
    reset = 1'b0;
    op_run(1'b0, 5'd5, 5'd3, 2'b00, 5'b01000, 4'b0000, 1'b0);

    // Both requests held from reset release
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
`ifdef ALU_ARB_RR_EN
      check("both_gnt0", 32'(gnt0), 32'(k != 1));
      check("both_gnt1", 32'(gnt1), 32'(k == 1));
`else
      check("both_gnt0", 32'(gnt0), 32'd1);
      check("both_gnt1", 32'(gnt1), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #2;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      a0 = DW'($urandom); b0 = DW'($urandom); op0 = 2'($urandom);
      a1 = DW'($urandom); b1 = DW'($urandom); op1 = 2'($urandom);
      @(posedge clk); #2;
    end

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
